ahbl_splitter: RTL and testbench
================================

Name: ahbl_splitter

Overview:
- 1:N AHB-Lite splitter: one master port fans out to N_PORTS slave ports by address decode.
- Sits between a hart's bus master and the per-slave N:1 arbiters.
- Exports the registered data-phase slave select so each downstream arbiter can resolve cross-hart ordering.
- Unmapped active transfers get a two-cycle AHB ERROR response from an internal default slave.

Parameters:
N_PORTS, 2, number of downstream slave ports
W_ADDR, 32, address width
W_DATA, 32, data width
ADDR_MAP, {N_PORTS{32'h0}}, concatenated per-port match base, port i at [i*W_ADDR +: W_ADDR]
ADDR_MASK, {N_PORTS{32'h0}}, concatenated per-port match mask, same packing

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
src_d_pc  in  W_ADDR  debug PC of issuing instruction, passed through
src_hartid  in  W_DATA  issuing hart id, passed through
src_hready  in  1  bus HREADY seen by master (address phase may advance)
src_hready_resp  out  1  HREADYOUT to master
src_hresp  out  1  HRESP to master
src_haddr/hwrite/htrans/hsize/hburst/hprot/hmastlock  in  W_ADDR/1/2/3/3/4/1  address-phase signals
src_hwdata  in  W_DATA  write data
src_hrdata  out  W_DATA  read data
src_hexcl  in  1  exclusive request
src_hmaster  in  8  master id
src_hexokay  out  1  exclusive okay
dst_d_pc, dst_hartid  out  N_PORTS*W_ADDR, N_PORTS*W_DATA  broadcast copies
dst_hready  out  N_PORTS  HREADY to each slave
dst_hready_resp  in  N_PORTS  HREADYOUT from each slave
dst_hresp  in  N_PORTS  HRESP from each slave
dst_haddr/hwrite/htrans/hsize/hburst/hprot/hmastlock  out  packed N_PORTS*width  address phase per slave
dst_hwdata  out  N_PORTS*W_DATA  broadcast write data
dst_hrdata  in  N_PORTS*W_DATA  slave read data
dst_hexcl  out  N_PORTS  exclusive request
dst_hmaster  out  N_PORTS*8  master id
dst_hexokay  in  N_PORTS  exclusive okay from slaves
slave_sel_d  out  N_PORTS  registered one-hot data-phase select

Behaviour:
- Decode (combinational): match[i] = ((src_haddr & ADDR_MASK[i]) == ADDR_MAP[i]). Multiple matches: lowest index wins. slave_sel_a = one-hot winner, gated by src_htrans[1]. Never more than one bit set.
- dst_htrans[i] = slave_sel_a[i] ? src_htrans : 2'b00.
- All other address-phase fields, d_pc, hartid, hexcl and hmaster are broadcast to every port unmodified.
- dst_hwdata is broadcast. dst_hready[i] = src_hready for all i.
- decode_err_a = src_htrans[1] && no match.
- Registered state, on src_hready high:
  - slave_sel_d <= slave_sel_a
  - err_pending <= decode_err_a
  - otherwise both hold.
- Default-slave FSM, states IDLE / ERR1 / ERR2:
  - IDLE -> ERR1 when src_hready && decode_err_a.
  - ERR1: src_hready_resp=0, src_hresp=1; next ERR2 unconditionally.
  - ERR2: src_hready_resp=1, src_hresp=1. Next is ERR1 if decode_err_a (src_hready is 1 here, so a new phase is accepted), else IDLE.
  - slave_sel_d is 0 throughout ERR1/ERR2.
- Response mux:
  - slave_sel_d != 0: src_hready_resp = |(slave_sel_d & dst_hready_resp); src_hresp = |(slave_sel_d & dst_hresp); src_hrdata = selected dst_hrdata; src_hexokay = |(slave_sel_d & dst_hexokay).
  - slave_sel_d == 0 and IDLE: src_hready_resp=1, src_hresp=0, src_hrdata=0, src_hexokay=0.
  - slave_sel_d == 0 and error state: FSM drives ready/resp; hrdata=0, hexokay=0.
- IDLE/BUSY htrans to an unmapped address: zero-wait OKAY, no error.
- Wait states: while the selected slave holds hready_resp low, src_hready is low. slave_sel_d is frozen and a new address phase is not registered. dst_htrans still reflects the live decode, as AHB requires.
- Reset values:
  - slave_sel_d=0, FSM=IDLE.
  - Hence src_hready_resp=1, src_hresp=0, src_hrdata=0, src_hexokay=0.
  - dst_* follow src_* combinationally.
- Reset mid-transfer (asynchronous) clears all state immediately; no response is completed.
- Latency: address decode 0 cycles; data-phase select available the cycle after address-phase acceptance.

Test Plan:
- N_PORTS=2, map0=0x0000_0000/mask 0xF000_0000, map1=0x8000_0000/mask 0xF000_0000. NONSEQ read 0x8000_0010 with src_hready=1 -> dst_htrans[1]=2'b10, dst_htrans[0]=0. Next cycle slave_sel_d=2'b10 and src_hrdata equals dst_hrdata port 1.
- Slave 0 holds hready_resp low for 3 cycles on a write to 0x100 -> src_hready_resp low for 3 cycles. slave_sel_d stays 01 and dst_hwdata stays stable.
- NONSEQ to 0x4000_0000 (unmapped) -> cycle+1: ready_resp=0, resp=1. Cycle+2: ready_resp=1, resp=1. Cycle+3: ready_resp=1, resp=0.
- Back-to-back unmapped NONSEQs -> ERR1, ERR2, ERR1, ERR2 with no IDLE between.
- Overlapping map (both masks 0, both match 0x1234) -> only port 0 selected. Exclusive write with dst_hexokay[0]=1 -> src_hexokay=1 in data phase.
- Assert rst_n low during ERR1 -> immediately src_hready_resp=1, src_hresp=0, slave_sel_d=0. After release, IDLE htrans gives zero-wait OKAY.

Source files
------------

// File: rtl/ahbl_splitter_if.sv
// AHB-Lite bus bundle with N packed lanes; N=1 for the master side, N=N_PORTS for the fan-out side.
// master drives the address phase and HREADY, slave returns HREADYOUT/HRESP/HRDATA/HEXOKAY.
interface ahbl_splitter_if #(
  parameter int N      = 1,
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  logic [N*W_ADDR-1:0] d_pc;
  logic [N*W_DATA-1:0] hartid;
  logic [N-1:0]        hready;
  logic [N-1:0]        hready_resp;
  logic [N-1:0]        hresp;
  logic [N*W_ADDR-1:0] haddr;
  logic [N-1:0]        hwrite;
  logic [N*2-1:0]      htrans;
  logic [N*3-1:0]      hsize;
  logic [N*3-1:0]      hburst;
  logic [N*4-1:0]      hprot;
  logic [N-1:0]        hmastlock;
  logic [N*W_DATA-1:0] hwdata;
  logic [N*W_DATA-1:0] hrdata;
  logic [N-1:0]        hexcl;
  logic [N*8-1:0]      hmaster;
  logic [N-1:0]        hexokay;

  modport master (
    output d_pc, hartid, hready, haddr, hwrite, htrans, hsize, hburst, hprot,
           hmastlock, hwdata, hexcl, hmaster,
    input  hready_resp, hresp, hrdata, hexokay
  );

  modport slave (
    input  d_pc, hartid, hready, haddr, hwrite, htrans, hsize, hburst, hprot,
           hmastlock, hwdata, hexcl, hmaster,
    output hready_resp, hresp, hrdata, hexokay
  );
endinterface

// File: rtl/ahbl_splitter.sv
// 1:N AHB-Lite splitter: address decode to one of N_PORTS slaves, registered data-phase select,
// and an internal default slave that answers unmapped active transfers with a two-cycle ERROR.
module ahbl_splitter #(
  parameter int                       N_PORTS   = 2,
  parameter int                       W_ADDR    = 32,
  parameter int                       W_DATA    = 32,
  parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MAP  = '0,
  parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MASK = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  ahbl_splitter_if.slave      src,
  ahbl_splitter_if.master     dst,
  output logic [N_PORTS-1:0]  slave_sel_d
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ERR1 = 2'd1,
    S_ERR2 = 2'd2
  } state_t;

  logic [N_PORTS-1:0] w_match;
  logic [N_PORTS-1:0] w_first;
  logic [N_PORTS-1:0] w_sel_a;
  logic               w_decode_err_a;
  logic [N_PORTS-1:0] r_slave_sel_d;
  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_err_ready;
  logic               w_err_resp;
  logic [W_DATA-1:0]  w_hrdata;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    assign w_match[gi] = (src.haddr & ADDR_MASK[gi*W_ADDR +: W_ADDR])
                         == ADDR_MAP[gi*W_ADDR +: W_ADDR];
    assign dst.htrans[gi*2 +: 2] = w_sel_a[gi] ? src.htrans : 2'b00;
  end

  // Scan from the top so the lowest matching index is the last one written and wins.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    w_first = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_first    = '0;
        w_first[i] = 1'b1;
      end
    end
  end

  assign w_sel_a        = w_first & {N_PORTS{src.htrans[1]}};
  assign w_decode_err_a = src.htrans[1] && (w_match == '0);

  assign dst.d_pc      = {N_PORTS{src.d_pc}};
  assign dst.hartid    = {N_PORTS{src.hartid}};
  assign dst.hready    = {N_PORTS{src.hready}};
  assign dst.haddr     = {N_PORTS{src.haddr}};
  assign dst.hwrite    = {N_PORTS{src.hwrite}};
  assign dst.hsize     = {N_PORTS{src.hsize}};
  assign dst.hburst    = {N_PORTS{src.hburst}};
  assign dst.hprot     = {N_PORTS{src.hprot}};
  assign dst.hmastlock = {N_PORTS{src.hmastlock}};
  assign dst.hwdata    = {N_PORTS{src.hwdata}};
  assign dst.hexcl     = {N_PORTS{src.hexcl}};
  assign dst.hmaster   = {N_PORTS{src.hmaster}};

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (!rst_n) begin
      r_slave_sel_d <= '0;
    end else if (src.hready) begin
      r_slave_sel_d <= w_sel_a;
    end
  end

  assign slave_sel_d = r_slave_sel_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ERR2 drives HREADYOUT high, so a new unmapped phase can be accepted there and chain into ERR1.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (src.hready && w_decode_err_a) w_state_nxt = S_ERR1;
      S_ERR1:  w_state_nxt = S_ERR2;
      S_ERR2:  w_state_nxt = (src.hready && w_decode_err_a) ? S_ERR1 : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_err_ready = 1'b1;
    w_err_resp  = 1'b0;
    case (r_state)
      S_ERR1:  begin w_err_ready = 1'b0; w_err_resp = 1'b1; end
      S_ERR2:  begin w_err_ready = 1'b1; w_err_resp = 1'b1; end
      default: begin w_err_ready = 1'b1; w_err_resp = 1'b0; end
    endcase
  end

  // AND-OR data mux: reads as zero whenever no slave owns the data phase.
  always_comb begin
    w_hrdata = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (r_slave_sel_d[i]) w_hrdata = w_hrdata | dst.hrdata[i*W_DATA +: W_DATA];
    end
  end

  always_comb begin
    if (r_slave_sel_d != '0) begin
      src.hready_resp = |(r_slave_sel_d & dst.hready_resp);
      src.hresp       = |(r_slave_sel_d & dst.hresp);
    end else begin
      src.hready_resp = w_err_ready;
      src.hresp       = w_err_resp;
    end
  end

  assign src.hrdata  = w_hrdata;
  assign src.hexokay = |(r_slave_sel_d & dst.hexokay);

endmodule

// File: tb/tb_ahbl_splitter.sv
// Self-checking bench for ahbl_splitter: directed vector table, reset/overlap sequences,
// and randomized traffic against a transaction-level reference model.
module tb_ahbl_splitter;

  localparam logic [31:0] D0 = 32'hA0A0_0000;
  localparam logic [31:0] D1 = 32'hB1B1_1111;
  localparam logic [31:0] WD = 32'hCAFE_F00D;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] sel_d;
  logic [1:0] ov_sel_d;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ahbl_splitter_if #(.N(1), .W_ADDR(32), .W_DATA(32)) src_bus ();
  ahbl_splitter_if #(.N(2), .W_ADDR(32), .W_DATA(32)) dst_bus ();
  ahbl_splitter_if #(.N(1), .W_ADDR(32), .W_DATA(32)) ov_src ();
  ahbl_splitter_if #(.N(2), .W_ADDR(32), .W_DATA(32)) ov_dst ();

  assign src_bus.hready = src_bus.hready_resp;
  assign ov_src.hready  = ov_src.hready_resp;

  ahbl_splitter #(
    .N_PORTS(2), .W_ADDR(32), .W_DATA(32),
    .ADDR_MAP ({32'h8000_0000, 32'h0000_0000}),
    .ADDR_MASK({32'hF000_0000, 32'hF000_0000})
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .src(src_bus), .dst(dst_bus), .slave_sel_d(sel_d)
  );

  ahbl_splitter #(
    .N_PORTS(2), .W_ADDR(32), .W_DATA(32),
    .ADDR_MAP ({32'h0000_0000, 32'h0000_0000}),
    .ADDR_MASK({32'h0000_0000, 32'h0000_0000})
  ) u_dut_ovl (
    .clk(clk), .rst_n(rst_n), .src(ov_src), .dst(ov_dst), .slave_sel_d(ov_sel_d)
  );

  typedef struct {
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [1:0]  rdy;
    logic [1:0]  e_sel;
    logic        e_rdy;
    logic        e_resp;
    logic [3:0]  e_htrans;
  } vec_t;

  vec_t tbl[22];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level decode: port 0 owns 0x0xxx_xxxx, port 1 owns 0x8xxx_xxxx, lowest index first.
  function automatic int ref_decode(input logic [31:0] a);
    if ((a & 32'hF000_0000) == 32'h0000_0000) return 0;
    if ((a & 32'hF000_0000) == 32'h8000_0000) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] rdata_for(input logic [1:0] sel);
    if (sel == 2'b01) return D0;
    if (sel == 2'b10) return D1;
    return 32'h0;
  endfunction

  task automatic init_inputs();
    src_bus.d_pc = 32'h0; src_bus.hartid = 32'h0; src_bus.haddr = 32'h0;
    src_bus.hwrite = 1'b0; src_bus.htrans = 2'b00; src_bus.hsize = 3'd2;
    src_bus.hburst = 3'd0; src_bus.hprot = 4'h3; src_bus.hmastlock = 1'b0;
    src_bus.hwdata = WD; src_bus.hexcl = 1'b0; src_bus.hmaster = 8'h00;
    dst_bus.hready_resp = 2'b11; dst_bus.hresp = 2'b00;
    dst_bus.hrdata = {D1, D0}; dst_bus.hexokay = 2'b00;
    ov_src.d_pc = 32'h0; ov_src.hartid = 32'h0; ov_src.haddr = 32'h0;
    ov_src.hwrite = 1'b0; ov_src.htrans = 2'b00; ov_src.hsize = 3'd2;
    ov_src.hburst = 3'd0; ov_src.hprot = 4'h3; ov_src.hmastlock = 1'b0;
    ov_src.hwdata = 32'h0; ov_src.hexcl = 1'b0; ov_src.hmaster = 8'h00;
    ov_dst.hready_resp = 2'b11; ov_dst.hresp = 2'b00;
    ov_dst.hrdata = 64'h0; ov_dst.hexokay = 2'b00;
  endtask

  task automatic fill_table();
    tbl[0]  = '{2'b00, 32'h0000_0000, 2'b11, 2'b00, 1'b1, 1'b0, 4'b0000};
    tbl[1]  = '{2'b10, 32'h8000_0010, 2'b11, 2'b00, 1'b1, 1'b0, 4'b1000};
    tbl[2]  = '{2'b00, 32'h0000_0000, 2'b11, 2'b10, 1'b1, 1'b0, 4'b0000};
    tbl[3]  = '{2'b10, 32'h0000_0100, 2'b11, 2'b00, 1'b1, 1'b0, 4'b0010};
    tbl[4]  = '{2'b00, 32'h0000_0000, 2'b10, 2'b01, 1'b0, 1'b0, 4'b0000};
    tbl[5]  = '{2'b10, 32'h8000_0000, 2'b10, 2'b01, 1'b0, 1'b0, 4'b1000};
    tbl[6]  = '{2'b10, 32'h8000_0000, 2'b10, 2'b01, 1'b0, 1'b0, 4'b1000};
    tbl[7]  = '{2'b10, 32'h8000_0000, 2'b11, 2'b01, 1'b1, 1'b0, 4'b1000};
    tbl[8]  = '{2'b00, 32'h0000_0000, 2'b11, 2'b10, 1'b1, 1'b0, 4'b0000};
    tbl[9]  = '{2'b00, 32'h0000_0000, 2'b11, 2'b00, 1'b1, 1'b0, 4'b0000};
    tbl[10] = '{2'b10, 32'h4000_0000, 2'b11, 2'b00, 1'b1, 1'b0, 4'b0000};
    tbl[11] = '{2'b00, 32'h0000_0000, 2'b11, 2'b00, 1'b0, 1'b1, 4'b0000};
    tbl[12] = '{2'b00, 32'h0000_0000, 2'b11, 2'b00, 1'b1, 1'b1, 4'b0000};
    tbl[13] = '{2'b00, 32'h0000_0000, 2'b11, 2'b00, 1'b1, 1'b0, 4'b0000};
    tbl[14] = '{2'b10, 32'h4000_0000, 2'b11, 2'b00, 1'b1, 1'b0, 4'b0000};
    tbl[15] = '{2'b10, 32'h4000_0004, 2'b11, 2'b00, 1'b0, 1'b1, 4'b0000};
    tbl[16] = '{2'b10, 32'h4000_0004, 2'b11, 2'b00, 1'b1, 1'b1, 4'b0000};
    tbl[17] = '{2'b00, 32'h0000_0000, 2'b11, 2'b00, 1'b0, 1'b1, 4'b0000};
    tbl[18] = '{2'b00, 32'h0000_0000, 2'b11, 2'b00, 1'b1, 1'b1, 4'b0000};
    tbl[19] = '{2'b00, 32'h0000_0000, 2'b11, 2'b00, 1'b1, 1'b0, 4'b0000};
    tbl[20] = '{2'b01, 32'h4000_0000, 2'b11, 2'b00, 1'b1, 1'b0, 4'b0000};
    tbl[21] = '{2'b00, 32'h0000_0000, 2'b11, 2'b00, 1'b1, 1'b0, 4'b0000};
  endtask

  // Reference model: which port (or default slave) owns the current data phase.
  int          m_dport;
  int          m_err;
  logic [31:0] addr;
  logic        e_rdy, e_resp, e_exok;
  logic [31:0] e_rdata;
  logic [3:0]  e_htrans;
  logic [1:0]  e_sel;
  int          p;

  initial begin
    rst_n = 1'b0;
    init_inputs();
    fill_table();
    #2;
    check("reset_sel", 64'(sel_d), 64'h0);
    check("reset_rdy", 64'(src_bus.hready_resp), 64'h1);
    check("reset_resp", 64'(src_bus.hresp), 64'h0);
    check("reset_rdata", 64'(src_bus.hrdata), 64'h0);
    check("reset_exokay", 64'(src_bus.hexokay), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      src_bus.htrans = tbl[i].htrans;
      src_bus.haddr  = tbl[i].haddr;
      src_bus.hwrite = (tbl[i].haddr == 32'h0000_0100);
      dst_bus.hready_resp = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("tbl%0d_sel", i), 64'(sel_d), 64'(tbl[i].e_sel));
      check($sformatf("tbl%0d_rdy", i), 64'(src_bus.hready_resp), 64'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_resp", i), 64'(src_bus.hresp), 64'(tbl[i].e_resp));
      check($sformatf("tbl%0d_htrans", i), 64'(dst_bus.htrans), 64'(tbl[i].e_htrans));
      check($sformatf("tbl%0d_rdata", i), 64'(src_bus.hrdata), 64'(rdata_for(tbl[i].e_sel)));
      check($sformatf("tbl%0d_wdata", i), 64'(dst_bus.hwdata), {WD, WD});
    end

    // Reset while port 1 stalls a data phase.
    @(posedge clk); #1;
    src_bus.htrans = 2'b10; src_bus.haddr = 32'h8000_0000; dst_bus.hready_resp = 2'b11;
    @(posedge clk); #1;
    src_bus.htrans = 2'b00; src_bus.haddr = 32'h0; dst_bus.hready_resp = 2'b01;
    @(negedge clk);
    check("wait_sel", 64'(sel_d), 64'h2);
    check("wait_rdy", 64'(src_bus.hready_resp), 64'h0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_wait_sel", 64'(sel_d), 64'h0);
    check("rst_wait_rdy", 64'(src_bus.hready_resp), 64'h1);
    check("rst_wait_rdata", 64'(src_bus.hrdata), 64'h0);
    @(negedge clk);
    rst_n = 1'b1; dst_bus.hready_resp = 2'b11;

    // Reset during ERR1, then a zero-wait OKAY for IDLE.
    @(posedge clk); #1;
    src_bus.htrans = 2'b10; src_bus.haddr = 32'h4000_0000;
    @(posedge clk); #1;
    src_bus.htrans = 2'b00; src_bus.haddr = 32'h0;
    @(negedge clk);
    check("err1_rdy", 64'(src_bus.hready_resp), 64'h0);
    check("err1_resp", 64'(src_bus.hresp), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_err_rdy", 64'(src_bus.hready_resp), 64'h1);
    check("rst_err_resp", 64'(src_bus.hresp), 64'h0);
    check("rst_err_sel", 64'(sel_d), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_rdy", 64'(src_bus.hready_resp), 64'h1);
    check("post_rst_resp", 64'(src_bus.hresp), 64'h0);

    // Overlapping map: port 0 wins, exclusive okay comes from the selected port only.
    @(posedge clk); #1;
    ov_src.htrans = 2'b10; ov_src.haddr = 32'h0000_1234; ov_src.hwrite = 1'b1;
    ov_src.hexcl = 1'b1; ov_dst.hexokay = 2'b01;
    @(negedge clk);
    check("ovl_htrans", 64'(ov_dst.htrans), 64'h2);
    check("ovl_hexcl", 64'(ov_dst.hexcl), 64'h3);
    @(posedge clk); #1;
    ov_src.htrans = 2'b00; ov_src.hexcl = 1'b0;
    @(negedge clk);
    check("ovl_sel", 64'(ov_sel_d), 64'h1);
    check("ovl_exokay", 64'(ov_src.hexokay), 64'h1);
    ov_dst.hexokay = 2'b10;
    #1;
    check("ovl_exokay_other", 64'(ov_src.hexokay), 64'h0);

    // Randomized traffic against the reference model (DUT is idle here).
    m_dport = -1;
    m_err   = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      case ($urandom_range(0, 3))
        0:       addr = {4'h0, 28'($urandom)};
        1:       addr = {4'h8, 28'($urandom)};
        2:       addr = {4'h4, 28'($urandom)};
        default: addr = $urandom;
      endcase
      src_bus.haddr     = addr;
      src_bus.htrans    = 2'($urandom_range(0, 3));
      src_bus.hwrite    = 1'($urandom);
      src_bus.hsize     = 3'($urandom);
      src_bus.hburst    = 3'($urandom);
      src_bus.hprot     = 4'($urandom);
      src_bus.hmastlock = 1'($urandom);
      src_bus.hexcl     = 1'($urandom);
      src_bus.hmaster   = 8'($urandom);
      src_bus.hwdata    = $urandom;
      src_bus.d_pc      = $urandom;
      src_bus.hartid    = $urandom;
      dst_bus.hready_resp = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      dst_bus.hresp       = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      dst_bus.hrdata      = {$urandom, $urandom};
      dst_bus.hexokay     = 2'($urandom);
      @(negedge clk);

      if (m_dport >= 0) begin
        e_sel   = 2'b00;
        e_sel[m_dport] = 1'b1;
        e_rdy   = dst_bus.hready_resp[m_dport];
        e_resp  = dst_bus.hresp[m_dport];
        e_rdata = dst_bus.hrdata[m_dport*32 +: 32];
        e_exok  = dst_bus.hexokay[m_dport];
      end else begin
        e_sel   = 2'b00;
        e_rdata = 32'h0;
        e_exok  = 1'b0;
        e_rdy   = (m_err != 2);
        e_resp  = (m_err != 0);
      end
      p = ref_decode(addr);
      e_htrans = 4'b0000;
      if (src_bus.htrans[1] && p >= 0) e_htrans[p*2 +: 2] = src_bus.htrans;

      check("rnd_sel", 64'(sel_d), 64'(e_sel));
      check("rnd_rdy", 64'(src_bus.hready_resp), 64'(e_rdy));
      check("rnd_resp", 64'(src_bus.hresp), 64'(e_resp));
      check("rnd_rdata", 64'(src_bus.hrdata), 64'(e_rdata));
      check("rnd_exokay", 64'(src_bus.hexokay), 64'(e_exok));
      check("rnd_htrans", 64'(dst_bus.htrans), 64'(e_htrans));
      check("rnd_haddr", dst_bus.haddr, {addr, addr});
      check("rnd_hwdata", dst_bus.hwdata, {2{src_bus.hwdata}});
      check("rnd_ctrl",
            64'({dst_bus.hwrite, dst_bus.hsize, dst_bus.hburst, dst_bus.hprot,
                 dst_bus.hmastlock, dst_bus.hexcl, dst_bus.hmaster, dst_bus.hready}),
            64'({{2{src_bus.hwrite}}, {2{src_bus.hsize}}, {2{src_bus.hburst}},
                 {2{src_bus.hprot}}, {2{src_bus.hmastlock}}, {2{src_bus.hexcl}},
                 {2{src_bus.hmaster}}, {2{e_rdy}}}));
      check("rnd_pc_hart", {dst_bus.d_pc[31:0] ^ dst_bus.d_pc[63:32], dst_bus.hartid[63:32]},
            {32'h0, src_bus.hartid});

      if (m_err == 2) begin
        m_err = 1;
      end else if (e_rdy) begin
        if (src_bus.htrans[1]) begin
          m_dport = p;
          m_err   = (p < 0) ? 2 : 0;
        end else begin
          m_dport = -1;
          m_err   = 0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
